imm_decode_stage: RTL and testbench

//  Immediate-generation pipeline stage in the ID phase of the 64-bit LEGv8 core.

---
 rtl/imm_decode_stage.sv | 80 ++++++++
 tb/tb_imm_decode_stage.sv | 133 +++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// Immediate-generation ID stage for the LEGv8 core. It decodes the immediate from the instruction and registers it with 1-cycle latency.
// stall holds all registered outputs. flush, or in_valid=0, registers a bubble. flush takes priority over stall.
module imm_decode_stage #(
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  output logic [DATA_W-1:0]  imm_out,
  output logic [2:0]         imm_type,
  output logic               imm_valid
);

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_D    = 3'd1,
    IMM_I    = 3'd2,
    IMM_B    = 3'd3,
    IMM_CB   = 3'd4,
    IMM_IW   = 3'd5
  } imm_fmt_e;

  imm_fmt_e          dec_type;
  logic [DATA_W-1:0] dec_imm;
  logic [DATA_W-1:0] movz_base;
  logic [5:0]        movz_shamt;

  assign movz_base  = {{(DATA_W-16){1'b0}}, instr[20:5]};
  assign movz_shamt = {instr[22:21], 4'b0000};

  // Opcode classes are tested widest-prefix first so the first match wins.
  always_comb begin
    dec_type = IMM_NONE;
    dec_imm  = '0;
    if (instr[31:21] == 11'b11111000010 || instr[31:21] == 11'b11111000000) begin
      dec_type = IMM_D;
      dec_imm  = {{(DATA_W-9){instr[20]}}, instr[20:12]};
    end else if (instr[31:22] == 10'b1001000100 || instr[31:22] == 10'b1101000100) begin
      dec_type = IMM_I;
      dec_imm  = {{(DATA_W-12){1'b0}}, instr[21:10]};
    end else if (instr[31:23] == 9'b110100101) begin
      dec_type = IMM_IW;
      dec_imm  = movz_base << movz_shamt;
    end else if (instr[31:24] == 8'b10110100 || instr[31:24] == 8'b10110101 ||
                 instr[31:24] == 8'b01010100) begin
      dec_type = IMM_CB;
      dec_imm  = {{(DATA_W-19){instr[23]}}, instr[23:5]};
    end else if (instr[31:26] == 6'b000101 || instr[31:26] == 6'b100101) begin
      dec_type = IMM_B;
      dec_imm  = {{(DATA_W-26){instr[25]}}, instr[25:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imm_out   <= '0;
      imm_type  <= IMM_NONE;
      imm_valid <= 1'b0;
    end else if (flush) begin
      imm_out   <= '0;
      imm_type  <= IMM_NONE;
      imm_valid <= 1'b0;
    end else if (!stall) begin
      if (in_valid) begin
        imm_out   <= dec_imm;
        imm_type  <= dec_type;
        imm_valid <= 1'b1;
      end else begin
        imm_out   <= '0;
        imm_type  <= IMM_NONE;
        imm_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed-vector bench for imm_decode_stage, using a vector table plus hand-written reset sequences.
module tb_imm_decode_stage;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [63:0] imm_out;
  logic [2:0]  imm_type;
  logic        imm_valid;

  int nvec = 0;
  int nerr = 0;

  imm_decode_stage dut (
    .clk      (clk),
    .reset    (reset),
    .instr    (instr),
    .in_valid (in_valid),
    .stall    (stall),
    .flush    (flush),
    .imm_out  (imm_out),
    .imm_type (imm_type),
    .imm_valid(imm_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        vld;
    logic        stl;
    logic        fl;
    logic [63:0] e_imm;
    logic [2:0]  e_type;
    logic        e_vld;
  } vec_t;

  vec_t tbl [0:23];

  task automatic check(input string name, input logic [63:0] e_imm,
                       input logic [2:0] e_type, input logic e_vld);
    nvec++;
    if (imm_out !== e_imm || imm_type !== e_type || imm_valid !== e_vld) begin
      nerr++;
      $display("FAIL %s: got imm=%h type=%0d valid=%b, want imm=%h type=%0d valid=%b",
               name, imm_out, imm_type, imm_valid, e_imm, e_type, e_vld);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic v, input logic s, input logic f);
    instr    = i;
    in_valid = v;
    stall    = s;
    flush    = f;
  endtask

  initial begin
    //                instr         vld   stl   fl    imm                     type  valid
    tbl[0]  = '{32'hF85C7041, 1'b1, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFC7, 3'd1, 1'b1};
    tbl[1]  = '{32'h913FFC00, 1'b1, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFC7, 3'd1, 1'b1};
    tbl[2]  = '{32'h913FFC00, 1'b1, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFC7, 3'd1, 1'b1};
    tbl[3]  = '{32'h913FFC00, 1'b1, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFC7, 3'd1, 1'b1};
    tbl[4]  = '{32'h913FFC00, 1'b1, 1'b0, 1'b0, 64'h0000000000000FFF, 3'd2, 1'b1};
    tbl[5]  = '{32'h17FFFFFF, 1'b1, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd3, 1'b1};
    tbl[6]  = '{32'hD2E24680, 1'b1, 1'b0, 1'b0, 64'h1234000000000000, 3'd5, 1'b1};
    tbl[7]  = '{32'hD2824680, 1'b1, 1'b0, 1'b0, 64'h0000000000001234, 3'd5, 1'b1};
    tbl[8]  = '{32'hD2A24680, 1'b1, 1'b0, 1'b0, 64'h0000000012340000, 3'd5, 1'b1};
    tbl[9]  = '{32'hD2C24680, 1'b1, 1'b0, 1'b0, 64'h0000123400000000, 3'd5, 1'b1};
    tbl[10] = '{32'hB4FFFFE0, 1'b1, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd4, 1'b1};
    tbl[11] = '{32'h54000020, 1'b1, 1'b0, 1'b0, 64'h0000000000000001, 3'd4, 1'b1};
    tbl[12] = '{32'hB5000040, 1'b1, 1'b0, 1'b0, 64'h0000000000000002, 3'd4, 1'b1};
    tbl[13] = '{32'hF8008000, 1'b1, 1'b0, 1'b0, 64'h0000000000000008, 3'd1, 1'b1};
    tbl[14] = '{32'hD1000400, 1'b1, 1'b0, 1'b0, 64'h0000000000000001, 3'd2, 1'b1};
    tbl[15] = '{32'h94000010, 1'b1, 1'b0, 1'b0, 64'h0000000000000010, 3'd3, 1'b1};
    tbl[16] = '{32'h97FFFFF0, 1'b1, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFF0, 3'd3, 1'b1};
    tbl[17] = '{32'hF840F000, 1'b1, 1'b0, 1'b0, 64'h000000000000000F, 3'd1, 1'b1};
    tbl[18] = '{32'h8B020020, 1'b1, 1'b0, 1'b0, 64'h0000000000000000, 3'd0, 1'b1};
    tbl[19] = '{32'h913FFC00, 1'b1, 1'b1, 1'b1, 64'h0000000000000000, 3'd0, 1'b0};
    tbl[20] = '{32'hF85C7041, 1'b1, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFC7, 3'd1, 1'b1};
    tbl[21] = '{32'h913FFC00, 1'b0, 1'b0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0};
    tbl[22] = '{32'hF85C7041, 1'b1, 1'b0, 1'b1, 64'h0000000000000000, 3'd0, 1'b0};
    tbl[23] = '{32'h913FFC00, 1'b1, 1'b1, 1'b0, 64'h0000000000000000, 3'd0, 1'b0};

    drive(32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #12;
    check("reset_state", 64'h0, 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      drive(tbl[k].instr, tbl[k].vld, tbl[k].stl, tbl[k].fl);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", k), tbl[k].e_imm, tbl[k].e_type, tbl[k].e_vld);
    end

    // Async reset between edges while the output holds a valid immediate.
    @(negedge clk);
    drive(32'hF85C7041, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("pre_async_reset", 64'hFFFFFFFFFFFFFFC7, 3'd1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_clear", 64'h0, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held_over_edge", 64'h0, 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(32'h00000000, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("post_reset_zero_instr", 64'h0, 3'd0, 1'b1);

    @(negedge clk);
    drive(32'h913FFC00, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("post_reset_addi", 64'h0000000000000FFF, 3'd2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
